// File: rtl/pipelined_adder.sv
// Pipelined adder: each stage adds one CHUNK-bit slice and forwards the carry,
// the finished low sum slices and the not-yet-added operand bits to the next stage.

module pipelined_adder_stage #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             ovf
);
    logic [CHUNK:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
    assign s    = full[CHUNK-1:0];
    assign co   = full[CHUNK];
    // Only meaningful in the top slice, where these MSBs are the word MSBs.
    assign ovf  = (a[CHUNK-1] == b[CHUNK-1]) && (s[CHUNK-1] != a[CHUNK-1]);
endmodule

module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / CHUNK;

    logic                adv;
    logic [STAGES:1]     vld_pipe;

    // Stage output registers; operands are kept shifted so the next slice sits at bit 0.
    logic [WIDTH-1:0]    a_q [STAGES];
    logic [WIDTH-1:0]    b_q [STAGES];
    logic [WIDTH-1:0]    s_q [STAGES];
    logic [STAGES-1:0]   c_q;
    logic                ovf_q;

    logic [WIDTH-1:0]    a_in [STAGES];
    logic [WIDTH-1:0]    b_in [STAGES];
    logic [WIDTH-1:0]    s_in [STAGES];
    logic [STAGES-1:0]   c_in;
    logic [WIDTH-1:0]    a_nx [STAGES];
    logic [WIDTH-1:0]    b_nx [STAGES];
    logic [WIDTH-1:0]    s_nx [STAGES];
    logic [STAGES-1:0]   c_nx;
    logic                v_nx [STAGES];
    logic [CHUNK-1:0]    s_sl [STAGES];

    // One global stall: every stage moves together or holds together.
    assign adv      = !vld_pipe[STAGES] || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        if (k == 0) begin : g_first
            assign a_in[k] = a;
            assign b_in[k] = b;
            assign c_in[k] = cin;
            assign s_in[k] = '0;
        end else begin : g_rest
            assign a_in[k] = a_q[k-1];
            assign b_in[k] = b_q[k-1];
            assign c_in[k] = c_q[k-1];
            assign s_in[k] = s_q[k-1];
        end

        pipelined_adder_stage #(
            .CHUNK (CHUNK)
        ) u_stg (
            .a   (a_in[k][CHUNK-1:0]),
            .b   (b_in[k][CHUNK-1:0]),
            .ci  (c_in[k]),
            .s   (s_sl[k]),
            .co  (c_nx[k]),
            .ovf (v_nx[k])
        );

        assign s_nx[k] = s_in[k] | (WIDTH'(s_sl[k]) << (k * CHUNK));
        assign a_nx[k] = a_in[k] >> CHUNK;
        assign b_nx[k] = b_in[k] >> CHUNK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            c_q      <= '0;
            ovf_q    <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv) begin
            vld_pipe[1] <= in_valid;
            for (int k = 2; k <= STAGES; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
            end
            c_q   <= c_nx;
            ovf_q <= v_nx[STAGES-1];
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_nx[k];
                b_q[k] <= b_nx[k];
                s_q[k] <= s_nx[k];
            end
        end
    end

    assign out_valid = vld_pipe[STAGES];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// Randomised and directed bench for pipelined_adder (16/4 and 16/16) with an
// arithmetic reference model and an in-order scoreboard on the 4-stage instance.

module tb_pipelined_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_ready;
    logic        in_ready, out_valid, cout, ovf;
    logic [15:0] sum;
    logic        in_ready2, out_valid2, cout2, ovf2;
    logic [15:0] sum2;

    typedef struct packed {
        logic        ovf;
        logic        cout;
        logic [15:0] sum;
    } res_t;

    res_t exq[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   n_out = 0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    pipelined_adder #(.WIDTH(16), .CHUNK(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid2), .out_ready(out_ready),
        .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow.
    function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic c);
        res_t        r;
        int unsigned u;
        int          s;
        u = int'(x) + int'(y) + int'(c);
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        r.sum  = u[15:0];
        r.cout = u[16];
        r.ovf  = (s > 32767) || (s < -32768);
        return r;
    endfunction

    // Scoreboard for the 4-stage instance: everything accepted must come out, in order.
    always @(negedge clk) begin
        if (rst) begin
            exq.delete();
        end else begin
            if (out_valid && out_ready) begin
                chk("stale", 32'(exq.size() != 0), 1);
                if (exq.size() != 0) begin
                    res_t e;
                    e = exq.pop_front();
                    chk("sb_sum", sum, e.sum);
                    chk("sb_cout", cout, e.cout);
                    chk("sb_ovf", ovf, e.ovf);
                    n_out++;
                end
            end
            if (in_valid && in_ready) exq.push_back(model(a, b, cin));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom);
    endtask

    // One transaction into both instances; checks values and latency of each.
    task automatic run_one(input logic [15:0] x, input logic [15:0] y, input logic c,
                           input logic [15:0] es, input logic ec, input logic eo);
        int n  = 0;
        int n4 = 0;
        int n1 = 0;
        a = x; b = y; cin = c; in_valid = 1'b1; out_ready = 1'b1;
        while (n < 20 && (n4 == 0 || n1 == 0)) begin
            @(posedge clk);
            #1 in_valid = 1'b0;
            n++;
            @(negedge clk);
            if (out_valid && n4 == 0) begin
                n4 = n;
                chk("d4_sum", sum, es);
                chk("d4_cout", cout, ec);
                chk("d4_ovf", ovf, eo);
            end
            if (out_valid2 && n1 == 0) begin
                n1 = n;
                chk("d1_sum", sum2, es);
                chk("d1_cout", cout2, ec);
                chk("d1_ovf", ovf2, eo);
            end
        end
        chk("lat4", n4, 4);
        chk("lat1", n1, 1);
        tick();
    endtask

    initial begin
        logic [31:0] vseq;
        logic [15:0] hs;
        logic        hc, ho;
        int          acc;
        int          base;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ov", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_ir", in_ready, 1);
        chk("rst_ov1", out_valid2, 0);
        chk("rst_sum1", sum2, 0);
        tick();

        run_one(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_one(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_one(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1);
        run_one(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

        // Back-to-back stream of 10: expect valid exactly on cycles 4..13.
        vseq = '0;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_valid = (c < 10);
            rand_ops();
            @(negedge clk);
            vseq[c] = out_valid;
            tick();
        end
        in_valid = 1'b0;
        chk("stream_vld", vseq, 32'h0000_3FF0);

        // Backpressure: 6 offered with out_ready low, only 4 fit.
        base = n_out;
        acc  = 0;
        out_ready = 1'b0;
        hs = '0; hc = 1'b0; ho = 1'b0;
        for (int c = 0; c < 7; c++) begin
            in_valid = (c < 6);
            rand_ops();
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            if (c == 4) begin
                hs = sum; hc = cout; ho = ovf;
                chk("bp_ov", out_valid, 1);
            end
            if (c > 4) begin
                chk("bp_hold_sum", sum, hs);
                chk("bp_hold_cout", cout, hc);
                chk("bp_hold_ovf", ovf, ho);
            end
            tick();
        end
        chk("bp_acc", acc, 4);
        chk("bp_ir", in_ready, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) tick();
        chk("bp_drain", n_out - base, 4);

        // Reset with 3 transactions in flight: nothing may emerge afterwards.
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            rand_ops();
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("mrst_ov", out_valid, 0);
            chk("mrst_ir", in_ready, 1);
            tick();
        end

        // Random traffic with random stalls.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            rand_ops();
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();
        chk("final_empty", exq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, giving the bits added per pipeline stage; WIDTH SHALL be an integer multiple of CHUNK, and STAGES = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operand set is valid this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand set this cycle.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: unsigned/two's-complement addends.
REQ-008 The block SHALL have port cin, input, 1 bit: carry-in.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port sum, output, WIDTH bits: a+b+cin modulo 2^WIDTH.
REQ-012 The block SHALL have port cout, output, 1 bit: carry out of the MSB.
REQ-013 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-014 Stage k (0..STAGES-1) SHALL add bits [k*CHUNK +: CHUNK] of a, b and the carry from stage k-1 (cin for stage 0), register that sum slice plus the carry, and delay the not-yet-added upper operand bits alongside.
REQ-015 Already-computed lower sum slices SHALL travel with their operand set, so sum, cout and ovf at the output all belong to a single transaction.
REQ-016 Each stage SHALL hold a valid bit; out_valid SHALL equal the valid bit of the last stage.
REQ-017 The pipeline SHALL advance when adv = !out_valid || out_ready, and SHALL hold every stage (data and valid) when adv=0.
REQ-018 in_ready SHALL equal adv, combinationally.
REQ-019 A transfer SHALL occur when in_valid && in_ready; if in_valid=0 while adv=1, a bubble (valid=0) SHALL enter stage 0.
REQ-020 Latency from accepted input to out_valid SHALL be exactly STAGES cycles when out_ready stays high.
REQ-021 Throughput SHALL be one result per cycle with out_ready held high, with no gap between back-to-back inputs.
REQ-022 While out_valid=1 and out_ready=0, sum, cout and ovf SHALL stay stable.
REQ-023 cout SHALL be the carry out of bit WIDTH-1.
REQ-024 ovf SHALL be (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), with cin included in the sum.
REQ-025 A zero-width carry chain between stages SHALL NOT occur; each stage's carry-in SHALL come only from the preceding stage's register.
REQ-026 When STAGES=1 (CHUNK=WIDTH), the block SHALL act as a registered WIDTH-bit adder with latency 1 and the same handshake.
REQ-027 The result for all-ones + all-ones + cin=1 SHALL be sum=all-ones and cout=1, with no truncation.

Reset
REQ-028 While rst=1 at a clock edge, every stage valid bit SHALL clear to 0, and out_valid SHALL read 0 after that edge.
REQ-029 After reset, sum, cout and ovf SHALL read 0, and all stage data registers SHALL clear to 0.
REQ-030 An assertion of rst mid-operation SHALL discard all in-flight transactions, and no result from before reset SHALL ever appear.
REQ-031 in_ready SHALL be 1 in the first cycle after reset is released.

Verification (WIDTH=16, CHUNK=4)
REQ-032 The bench SHALL drive a=0xFFFF, b=0x0001, cin=0 with out_ready=1 -> after 4 cycles out_valid=1, sum=0x0000, cout=1, ovf=0.
REQ-033 The bench SHALL drive a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; and a=0x8000, b=0x8000, cin=1 -> sum=0x0001, cout=1, ovf=1.
REQ-034 The bench SHALL stream 10 random operand sets on consecutive cycles with out_ready=1 -> 10 consecutive valid results, in order, each matching a+b+cin, the first at cycle 4.
REQ-035 The bench SHALL hold out_ready=0 for 6 cycles with 6 inputs offered -> exactly 4 accepted and in_ready=0 thereafter, output stable; on release the results drain in order with none lost or duplicated.
REQ-036 The bench SHALL assert rst for 1 cycle while 3 transactions are in flight -> out_valid=0 for the following 4 cycles with no stale result, and in_ready=1.
REQ-037 The bench SHALL rerun REQ-032 with CHUNK=16 -> latency 1 and the same values.
